lzc_normalizer: RTL and testbench

Parametrised, pipelined leading-zero counter and left-normalizer for the floating-point adder datapath. It accepts a WIDTH-bit mantissa with a valid/ready handshake and returns the leading-zero count, the mantissa shifted left by that count, and an all-zero flag, two cycles later. A TAG_W-bit sideband (sign/exponent/rounding bits) travels alongside the data. It generalises the fixed 24-bit combinational counter into a streaming, back-pressurable stage that can sit between the mantissa add and the exponent adjust.

---
 rtl/fp_pkg.sv | 15 +
 rtl/lzc_tree.sv | 35 +++
 rtl/lzc_normalizer.sv | 133 +++++++++++++
 tb/tb_lzc_normalizer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared floating-point datapath constants and the clog2 helper
package fp_pkg;

  localparam int FP_MANT_W = 24;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lzc_tree.sv
// rtl/lzc_tree.sv - combinational leading-zero counter built as a binary priority tree
// Input is padded with ones up to a power of two so an all-zero word counts WIDTH.
module lzc_tree
  import fp_pkg::*;
#(
  parameter  int WIDTH = FP_MANT_W,
  localparam int CNT_W = clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);

  localparam int PAD_W = 1 << CNT_W;

  logic [PAD_W-1:0] padded;

  assign padded = {data, {(PAD_W - WIDTH){1'b1}}};

  // Each level halves the node count in place: the upper child wins if it holds a one,
  // otherwise the lower child's count is offset by the upper child's span.
  always_comb begin : tree
    logic [PAD_W-1:0] v;
    logic [CNT_W-1:0] c [PAD_W];
    v = padded;
    c = '{default: '0};
    for (int l = 0; l < CNT_W; l++) begin
      for (int i = 0; i < (PAD_W >> (l + 1)); i++) begin
        c[i] = v[2*i+1] ? c[2*i+1] : (c[2*i] | CNT_W'(1 << l));
        v[i] = v[2*i+1] | v[2*i];
      end
    end
    count = c[0];
  end

endmodule

// File: rtl/lzc_normalizer.sv
// rtl/lzc_normalizer.sv - two-stage streaming leading-zero count and left-normalize
// Optional LZC_SKID_EN adds a 2-entry skid buffer so in_ready comes straight from a flop.
module lzc_normalizer
  import fp_pkg::*;
#(
  parameter  int WIDTH = FP_MANT_W,
  parameter  int TAG_W = 8,
  localparam int CNT_W = clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  logic             src_valid;
  logic [WIDTH-1:0] src_data;
  logic [TAG_W-1:0] src_tag;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [TAG_W-1:0] s1_tag;
  logic [CNT_W-1:0] s1_count;

  logic             s1_advance;
  logic             s2_advance;
  logic [CNT_W-1:0] tree_count;

  assign s2_advance = s1_valid && (!out_valid || out_ready);
  assign s1_advance = src_valid && (!s1_valid || s2_advance);

`ifdef LZC_SKID_EN
  logic [WIDTH-1:0] sk_data [2];
  logic [TAG_W-1:0] sk_tag  [2];
  logic [1:0]       sk_cnt;
  logic [1:0]       sk_cnt_nxt;
  logic             in_ready_q;
  logic             in_fire;
  logic             s1_can_load;
  logic             sk_pop;
  logic             sk_push;
  logic             sk_wr_idx;

  assign in_ready    = in_ready_q;
  assign in_fire     = in_valid && in_ready_q;
  assign s1_can_load = !s1_valid || s2_advance;

  // An empty buffer is bypassed so an idle pipe keeps its two-cycle latency.
  assign src_valid = (sk_cnt != 2'd0) || in_fire;
  assign src_data  = (sk_cnt != 2'd0) ? sk_data[0] : in_data;
  assign src_tag   = (sk_cnt != 2'd0) ? sk_tag[0]  : in_tag;

  assign sk_pop     = (sk_cnt != 2'd0) && s1_can_load;
  assign sk_push    = in_fire && !((sk_cnt == 2'd0) && s1_can_load);
  assign sk_cnt_nxt = sk_cnt + {1'b0, sk_push} - {1'b0, sk_pop};
  assign sk_wr_idx  = (sk_cnt == 2'd1) && !sk_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      sk_cnt     <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      sk_cnt     <= sk_cnt_nxt;
      in_ready_q <= (sk_cnt_nxt != 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (sk_pop) begin
      sk_data[0] <= sk_data[1];
      sk_tag[0]  <= sk_tag[1];
    end
    if (sk_push) begin
      sk_data[sk_wr_idx] <= in_data;
      sk_tag[sk_wr_idx]  <= in_tag;
    end
  end
`else
  assign src_valid = in_valid;
  assign src_data  = in_data;
  assign src_tag   = in_tag;
  assign in_ready  = !s1_valid || s2_advance;
`endif

  lzc_tree #(.WIDTH(WIDTH)) u_lzc_tree (
    .data  (src_data),
    .count (tree_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_tag   <= '0;
      s1_count <= '0;
    end else if (s1_advance) begin
      s1_valid <= 1'b1;
      s1_data  <= src_data;
      s1_tag   <= src_tag;
      s1_count <= tree_count;
    end else if (s2_advance) begin
      s1_valid <= 1'b0;
    end
  end

  // Shifting by a count of WIDTH clears the word, which is the all-zero result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_count <= '0;
      out_data  <= '0;
      out_zero  <= 1'b0;
      out_tag   <= '0;
    end else if (s2_advance) begin
      out_valid <= 1'b1;
      out_count <= s1_count;
      out_data  <= s1_data << s1_count;
      out_zero  <= (s1_count == CNT_W'(WIDTH));
      out_tag   <= s1_tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lzc_normalizer.sv
// tb/tb_lzc_normalizer.sv - self-checking bench for lzc_normalizer at WIDTH 24 and 53
module tb_lzc_normalizer;

`ifdef LZC_SKID_EN
  localparam int STALL_DEPTH = 4;
`else
  localparam int STALL_DEPTH = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [23:0] in_data, out_data;
  logic [7:0]  in_tag, out_tag;
  logic [4:0]  out_count;

  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_zero_b;
  logic [52:0] in_data_b, out_data_b;
  logic [7:0]  in_tag_b, out_tag_b;
  logic [5:0]  out_count_b;

  lzc_normalizer #(.WIDTH(24), .TAG_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_data(out_data), .out_zero(out_zero), .out_tag(out_tag)
  );

  lzc_normalizer #(.WIDTH(53), .TAG_W(8)) dut53 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b), .in_tag(in_tag_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_count(out_count_b),
    .out_data(out_data_b), .out_zero(out_zero_b), .out_tag(out_tag_b)
  );

  typedef struct {
    logic [6:0]  cnt;
    logic [63:0] data;
    logic        zero;
    logic [7:0]  tag;
  } beat_t;

  beat_t q24[$];
  beat_t q53[$];
  int total = 0;
  int bad = 0;
  int n53_in = 0;
  int n53_out = 0;

  function automatic beat_t model(input logic [63:0] v, input int w, input logic [7:0] tag);
    beat_t b;
    int n;
    logic [63:0] mask;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    v = v & mask;
    n = 0;
    while (n < w && v[w-1-n] == 1'b0) n++;
    b.cnt  = 7'(n);
    b.data = (v << n) & mask;
    b.zero = (v == 64'd0);
    b.tag  = tag;
    return b;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and hold-stability monitor for the 24-bit instance.
  initial begin
    beat_t e, held;
    logic stall;
    stall = 1'b0;
    held = '{default: '0};
    forever begin
      @(negedge clk);
      if (rst) begin
        q24.delete();
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold_valid", out_valid, 1);
          check("hold_count", out_count, held.cnt);
          check("hold_data", out_data, held.data);
          check("hold_zero", out_zero, held.zero);
          check("hold_tag", out_tag, held.tag);
        end
        if (in_valid && in_ready) q24.push_back(model(64'(in_data), 24, in_tag));
        if (out_valid && out_ready) begin
          check("out24_expected", q24.size() != 0, 1);
          if (q24.size() != 0) begin
            e = q24.pop_front();
            check("count24", out_count, e.cnt);
            check("data24", out_data, e.data);
            check("zero24", out_zero, e.zero);
            check("tag24", out_tag, e.tag);
          end
        end
        stall = out_valid && !out_ready;
        held.cnt = 7'(out_count);
        held.data = 64'(out_data);
        held.zero = out_zero;
        held.tag = out_tag;
      end
    end
  end

  // Scoreboard for the 53-bit instance.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        q53.delete();
      end else begin
        if (in_valid_b && in_ready_b) q53.push_back(model(64'(in_data_b), 53, in_tag_b));
        if (out_valid_b && out_ready_b) begin
          n53_out++;
          check("out53_expected", q53.size() != 0, 1);
          if (q53.size() != 0) begin
            e = q53.pop_front();
            check("count53", out_count_b, e.cnt);
            check("data53", out_data_b, e.data);
            check("zero53", out_zero_b, e.zero);
            check("tag53", out_tag_b, e.tag);
          end
        end
      end
    end
  end

  task automatic single(input logic [23:0] d, input logic [7:0] t, input logic [4:0] ec,
                        input logic [23:0] ed, input logic ez);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_tag = t;
    @(negedge clk);
    check("single_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("single_lat1", out_valid, 0);
    @(negedge clk);
    check("single_valid", out_valid, 1);
    check("single_count", out_count, ec);
    check("single_data", out_data, ed);
    check("single_zero", out_zero, ez);
    check("single_tag", out_tag, t);
  endtask

  task automatic wait_empty24();
    for (int i = 0; i < 100 && (q24.size() != 0 || out_valid); i++) @(negedge clk);
    check("drain24", q24.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic took;
    int acc, sent, seen;
    logic [63:0] v;

    in_valid = 0; in_data = '0; in_tag = '0; out_ready = 1;
    in_valid_b = 0; in_data_b = '0; in_tag_b = '0; out_ready_b = 1;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_zero", out_zero, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid53", out_valid_b, 0);

    single(24'h800000, 8'hA5, 5'd0, 24'h800000, 1'b0);
    single(24'h000001, 8'h3C, 5'd23, 24'h800000, 1'b0);
    single(24'h000000, 8'h0F, 5'd24, 24'h000000, 1'b1);
    wait_empty24();

    // Walking one, back to back: outputs must be contiguous two cycles behind.
    for (int i = 0; i < 26; i++) begin
      @(posedge clk); #1;
      if (i < 24) begin
        in_valid = 1'b1; in_data = 24'h1 << (23 - i); in_tag = 8'(i);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 24) check("stream_in_ready", in_ready, 1);
      check("stream_out_valid", out_valid, i >= 2);
      if (i >= 2) check("stream_count", out_count, i - 2);
    end
    wait_empty24();

    // Downstream stall: count how many beats the pipe absorbs before in_ready drops.
    @(posedge clk); #1;
    out_ready = 1'b0;
    acc = 0;
    took = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (took) begin in_data = 24'($urandom); in_tag = 8'($urandom); end
      in_valid = 1'b1;
      @(negedge clk);
      took = in_ready;
      if (in_ready) acc++;
    end
    check("stall_accepted", acc, STALL_DEPTH);
    check("stall_in_ready", in_ready, 0);
    sent = 0;
    for (int g = 0; g < 50 && sent < 4; g++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      if (took) begin in_data = 24'($urandom); in_tag = 8'($urandom); end
      in_valid = 1'b1;
      @(negedge clk);
      took = in_ready;
      if (in_ready) sent++;
    end
    check("release_sent", sent, 4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_empty24();

    // Reset with two beats in flight: neither may ever emerge.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 24'h00F000; in_tag = 8'h11;
    @(posedge clk); #1;
    in_data = 24'h000300; in_tag = 8'h22;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("inflight_valid", out_valid, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_count", out_count, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_tag", out_tag, 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("ghost_outputs", seen, 0);

    // Random traffic with random back-pressure on the 53-bit instance.
    took = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      out_ready_b = ($urandom_range(0, 3) != 0);
      if (!in_valid_b || took) begin
        in_valid_b = ($urandom_range(0, 4) != 0);
        v = {$urandom(), $urandom()};
        v = v >> $urandom_range(0, 60);
        if ($urandom_range(0, 15) == 0) v = 64'd0;
        in_data_b = v[52:0];
        in_tag_b = 8'($urandom);
      end
      @(negedge clk);
      took = in_valid_b && in_ready_b;
      if (took) n53_in++;
    end
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    out_ready_b = 1'b1;
    for (int i = 0; i < 100 && (q53.size() != 0 || out_valid_b); i++) @(negedge clk);
    check("drain53", q53.size(), 0);
    check("rand53_beats", n53_out, n53_in);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
